cpu_run_ctrl: RTL
=================

# cpu_run_ctrl

Run/step/breakpoint sequencer for the single-cycle RISC-V core. It sits between the board switches/button and the core, and issues a one-`clk` instruction-enable pulse (`cpu_en`) that gates the PC, RF and DM updates. This replaces free-running divided clocks, so the whole core runs on `clk`. It supports continuous run at two selectable rates, debounced single-step, a PC breakpoint and a retired-instruction counter for the display path.

## Interface
- `TICK_DIV`, 25_000_000: `clk` cycles per instruction in fast run; must be ≥ 2.
- `DBNC_CYC`, 1_000_000: consecutive stable cycles required to accept a `step_btn` level change.
- `PC_W`, 32: width of `pc`/`bp_addr`.
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active-high.
- `run_sw` in 1: level; 1 = run, 0 = halt.
- `slow_sel` in 1: level; 1 = run period `TICK_DIV*8`, 0 = `TICK_DIV`.
- `step_btn` in 1: raw asynchronous push-button.
- `bp_en` in 1: breakpoint enable.
- `bp_addr` in `PC_W`: breakpoint PC.
- `pc` in `PC_W`: current core PC (address of instruction about to execute).
- `cpu_en` out 1: registered; high for exactly one `clk` per instruction to execute.
- `halted` out 1: registered; 1 whenever state ≠ RUN.
- `bp_hit` out 1: registered; 1 while state = BRK.
- `state` out 2: HALT=00, RUN=01, STEP=10, BRK=11.
- `instr_cnt` out 32: count of `cpu_en` pulses since reset.

## Operation
- Button path: 2-FF synchronizer → debouncer. The debouncer keeps a counter that runs while the synced level ≠ the debounced level and clears otherwise. When the count reaches `DBNC_CYC`, the debounced level takes the synced level. `press` is a one-cycle pulse registered on the debounced rising edge. Release produces no event.
- Tick: `tick_cnt` counts only in RUN and clears in every other state. Let N = `slow_sel` ? `TICK_DIV*8` : `TICK_DIV`. `tick` = (`tick_cnt` ≥ N−1), and on `tick` the counter wraps to 0. Because the compare is ≥, a `slow_sel` change mid-count never overshoots.
- FSM, next-state priority as listed:
  - HALT: `run_sw`=1 → RUN. Otherwise `press` → STEP.
  - STEP: `cpu_en`=1 this cycle → HALT. The breakpoint is not checked.
  - RUN: `run_sw`=0 → HALT, with no pulse even if `tick` fires in the same cycle. Otherwise, on `tick`:
    - if `bp_en` && `pc`==`bp_addr` && !`skip` → BRK, no pulse;
    - else `cpu_en` pulse and `skip` cleared.
  - BRK: `run_sw`=0 → HALT with `skip` cleared. Otherwise `press` → `cpu_en` pulse, `skip` set, → RUN.
- `skip` lets the instruction at the breakpoint retire once after resume. Entering RUN from HALT with `pc`==`bp_addr` stops at BRK on the first tick.
- `press` arriving in RUN or STEP is discarded.
- `instr_cnt` increments on every `cpu_en` and wraps 0xFFFF_FFFF → 0.
- Reset values:
  - state HALT, `cpu_en` 0, `halted` 1, `bp_hit` 0, `instr_cnt` 0;
  - `skip` 0, `tick_cnt` 0, debounced level 0, synchronizer 0, debounce counter 0.

## Timing
- Run: if RUN is entered at cycle t, `cpu_en` goes high at t+N, t+2N, … (period N, width 1).
- Step: with `step_btn` rising and held stable from cycle 0, `cpu_en` is high at cycle `DBNC_CYC`+4 and nowhere else.
- Stages: sync 2, debounce `DBNC_CYC`, `press` register 1, STEP entry 1.
- BRK resume: `cpu_en` is high the cycle after `press`. The next run pulse follows N cycles after that.
- `halted`, `bp_hit` and `state` change in the same cycle as the state register.
- The core must sample PC/RF/DM writes only on `clk` edges where `cpu_en`=1. The `pc` input is stable between pulses.
- `rst` asserted mid-operation forces the reset values on the next edge, including abandoning a debounce in progress.

## Configuration
- `CPU_RUN_CTRL_BP_EN`, defined: breakpoint compare, `skip`, and BRK state present as above.
- Undefined: `bp_en`/`bp_addr`/`pc` are ignored, BRK is unreachable, `bp_hit` is tied 0, and RUN pulses on every `tick`.

## Test plan
- Reset with `run_sw`=1 held: outputs hold reset values while `rst`=1. Then, with `TICK_DIV`=4, `cpu_en` pulses at cycles 4, 8, 12 after RUN entry, and `instr_cnt`=3 after the third pulse.
- `DBNC_CYC`=4: a 3-cycle `step_btn` glitch → no pulse. A held press → exactly one `cpu_en` at cycle 8, state STEP→HALT, `instr_cnt`+1.
- `bp_en`=1, `bp_addr`=0x10, `pc` stepping 0x0C→0x10 in RUN → BRK on the next tick, `bp_hit`=1, no pulse. A press then gives one pulse and return to RUN, and the next tick pulses despite `pc` still being 0x10.
- `run_sw` 1→0 in the same cycle that `tick` fires → no pulse, HALT, and `tick_cnt` is 0 on the next cycle.
- `slow_sel` 0→1 with `TICK_DIV`=4 and `tick_cnt`=2 → pulse period becomes 32. A 1→0 change with `tick_cnt`=20 → immediate tick.
- `instr_cnt` preloaded via force to 0xFFFF_FFFF → next pulse gives 0. Macro undefined build: a breakpoint match never stops the core and `bp_hit` stays 0.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/breakpoint sequencer for the single-cycle core.
// Issues a one-clk instruction enable (cpu_en_o) so the whole core runs on clk_i.
// Ports: clk_i/rst_i (sync, active-high); run_sw_i, slow_sel_i, step_btn_i (raw
//   button), bp_en_i/bp_addr_i/pc_i (breakpoint compare) in; cpu_en_o, halted_o,
//   bp_hit_o, state_o (HALT=00 RUN=01 STEP=10 BRK=11), instr_cnt_o out.
// Option: define CPU_RUN_CTRL_BP_EN to build the breakpoint compare, skip flag
//   and BRK state; without it the breakpoint inputs are ignored.
module cpu_run_ctrl #(
  parameter int TICK_DIV = 25_000_000,
  parameter int DBNC_CYC = 1_000_000,
  parameter int PC_W     = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            run_sw_i,
  input  logic            slow_sel_i,
  input  logic            step_btn_i,
  input  logic            bp_en_i,
  input  logic [PC_W-1:0] bp_addr_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            cpu_en_o,
  output logic            halted_o,
  output logic            bp_hit_o,
  output logic [1:0]      state_o,
  output logic [31:0]     instr_cnt_o
);

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_BRK  = 2'b11
  } state_e;

  localparam int TW = $clog2(TICK_DIV * 8);
  localparam int DW = $clog2(DBNC_CYC + 1);
  localparam logic [TW-1:0] LIM_FAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] LIM_SLOW = TW'(TICK_DIV * 8 - 1);

  // ---------------- button path: sync -> debounce -> rising-edge pulse
  logic          sync1_q, sync2_q;
  logic          db_q, db_d, db_prev_q;
  logic          press_q;
  logic [DW-1:0] dbnc_cnt_q, dbnc_cnt_d;

  // The counter runs only while the synced level disagrees with the accepted
  // level; any agreement restarts it, so a short glitch never gets through.
  always_comb begin
    dbnc_cnt_d = '0;
    db_d       = db_q;
    if (sync2_q != db_q) begin
      if (dbnc_cnt_q == DW'(DBNC_CYC - 1)) begin
        db_d = sync2_q;
      end else begin
        dbnc_cnt_d = dbnc_cnt_q + DW'(1);
      end
    end
  end

  // ---------------- instruction tick
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [TW-1:0] tick_lim;
  logic          tick;
  state_e        state_q, state_d;

  // ">=" rather than "==" so that shrinking the period mid-count fires at once
  // instead of wrapping through the full counter range.
  assign tick_lim = slow_sel_i ? LIM_SLOW : LIM_FAST;
  assign tick     = (state_q == S_RUN) && (tick_cnt_q >= tick_lim);

  always_comb begin
    tick_cnt_d = '0;
    if ((state_q == S_RUN) && !tick) begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  // ---------------- breakpoint compare
`ifdef CPU_RUN_CTRL_BP_EN
  logic skip_q, skip_d;
  logic bp_match;
  // skip lets the instruction sitting at the breakpoint retire once on resume.
  assign bp_match = bp_en_i && (pc_i == bp_addr_i) && !skip_q;
`else
  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{bp_en_i, bp_addr_i, pc_i};
`endif

  // ---------------- sequencer FSM
  logic        cpu_en_q, cpu_en_d;
  logic        halted_q, bp_hit_q;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
`ifdef CPU_RUN_CTRL_BP_EN
    skip_d   = skip_q;
`endif
    unique case (state_q)
      S_HALT: begin
        if (run_sw_i) begin
          state_d = S_RUN;
        end else if (press_q) begin
          state_d  = S_STEP;
          cpu_en_d = 1'b1;
        end
      end
      S_STEP: begin
        // The single-step pulse is issued on entry; leave as soon as it is out.
        if (cpu_en_q) begin
          state_d = S_HALT;
        end
      end
      S_RUN: begin
        if (!run_sw_i) begin
          state_d = S_HALT;
`ifdef CPU_RUN_CTRL_BP_EN
          skip_d  = 1'b0;
`endif
        end else if (tick) begin
`ifdef CPU_RUN_CTRL_BP_EN
          if (bp_match) begin
            state_d = S_BRK;
          end else begin
            cpu_en_d = 1'b1;
            skip_d   = 1'b0;
          end
`else
          cpu_en_d = 1'b1;
`endif
        end
      end
      S_BRK: begin
`ifdef CPU_RUN_CTRL_BP_EN
        if (!run_sw_i) begin
          state_d = S_HALT;
          skip_d  = 1'b0;
        end else if (press_q) begin
          state_d  = S_RUN;
          cpu_en_d = 1'b1;
          skip_d   = 1'b1;
        end
`else
        state_d = S_HALT;
`endif
      end
      default: state_d = S_HALT;
    endcase
  end

  assign instr_cnt_d = instr_cnt_q + {31'b0, cpu_en_d};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_q        <= 1'b0;
      db_prev_q   <= 1'b0;
      press_q     <= 1'b0;
      dbnc_cnt_q  <= '0;
      tick_cnt_q  <= '0;
      state_q     <= S_HALT;
      cpu_en_q    <= 1'b0;
      halted_q    <= 1'b1;
      bp_hit_q    <= 1'b0;
      instr_cnt_q <= '0;
`ifdef CPU_RUN_CTRL_BP_EN
      skip_q      <= 1'b0;
`endif
    end else begin
      sync1_q     <= step_btn_i;
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      db_prev_q   <= db_q;
      press_q     <= db_q && !db_prev_q;
      dbnc_cnt_q  <= dbnc_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      cpu_en_q    <= cpu_en_d;
      halted_q    <= (state_d != S_RUN);
      bp_hit_q    <= (state_d == S_BRK);
      instr_cnt_q <= instr_cnt_d;
`ifdef CPU_RUN_CTRL_BP_EN
      skip_q      <= skip_d;
`endif
    end
  end

  assign cpu_en_o    = cpu_en_q;
  assign halted_o    = halted_q;
  assign bp_hit_o    = bp_hit_q;
  assign state_o     = state_q;
  assign instr_cnt_o = instr_cnt_q;

endmodule
